// File: rtl/store_buffer_unit_pkg.sv
// store_buffer_unit_pkg: store size codes, store opcode prefix and buffer entry type
package store_buffer_unit_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_LR   = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;
  localparam logic [2:0] ST_OP   = 3'b101;
  localparam int SB_DEPTH = 4;
  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } entry_t;
endpackage

// File: rtl/store_buffer_unit_align.sv
// store_align: places sb/sh/sw data into byte lanes and builds the byte enable
module store_align
  import store_buffer_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr,
  input  logic [31:0] data,
  output logic [3:0]  be,
  output logic [31:0] wdata
);
  assign be = size == SZ_WORD ? 4'b1111 :
              size == SZ_HALF ? (addr[1] ? 4'b1100 : 4'b0011) :
              4'b0001 << addr;
  assign wdata = size == SZ_WORD ? data :
                 size == SZ_HALF ? {2{data[15:0]}} :
                 {4{data[7:0]}};
endmodule

// File: rtl/store_buffer_unit.sv
// store_buffer_unit: aligns MEM-stage stores, queues them in order and drains them to data RAM
module store_buffer_unit
  import store_buffer_unit_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Inst,
  input  logic [31:0] AO,
  input  logic [31:0] RT_data,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        load_valid,
  output logic        load_conflict,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        empty
);
  localparam int PW = $clog2(DEPTH);
  entry_t q [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0] count;
  logic [3:0] al_be;
  logic [31:0] al_wdata;
  logic is_store, push, pop, hit;
  assign is_store  = Inst[31:29] == ST_OP && Inst[27:26] != SZ_LR;
  assign req_ready = count != (PW+1)'(DEPTH);
  assign mem_valid = count != '0;
  assign empty     = !mem_valid;
  assign push      = req_valid & is_store & req_ready;
  assign pop       = mem_valid & mem_ready;
  assign mem_addr  = mem_valid ? q[rd_ptr].addr : '0;
  assign mem_wdata = mem_valid ? q[rd_ptr].wdata : '0;
  assign mem_be    = mem_valid ? q[rd_ptr].be : '0;
  store_align u_align (
    .size (Inst[27:26]),
    .addr (AO[1:0]),
    .data (RT_data),
    .be   (al_be),
    .wdata(al_wdata)
  );
  // whole-word match against every pending entry; the store being pushed has address AO too
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) hit = hit | (vld[i] && q[i].addr == AO[31:2]);
    load_conflict = load_valid & (hit | push);
  end
  // FIFO storage, pointers and occupancy; a full buffer refuses pushes even when popping
  always_ff @(posedge clk) begin
    if (reset) begin
      vld    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + 1'b1;
      end
      if (push) begin
        q[wr_ptr]   <= '{addr: AO[31:2], wdata: al_wdata, be: al_be};
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
endmodule
